// File: rtl/jesd204b_scrambler_array_pkg.sv
// JESD204B scrambler shared definitions.
// Polynomial 1 + x^14 + x^15 taps, default seed, lock states.
package jesd204b_pkg;

  localparam int JESD_SCR_LEN   = 15;
  localparam int JESD_SCR_TAP_A = 14;
  localparam int JESD_SCR_TAP_B = 15;

  localparam logic [JESD_SCR_LEN-1:0] JESD_SCR_SEED_DEF = 15'h7F80;

  typedef enum logic [1:0] {
    LK_UNLOCKED,
    LK_ONE_SEEN,
    LK_LOCKED
  } lock_state_t;

endpackage

// File: rtl/jesd204b_scrambler_array_if.sv
// Valid-only lane beat bus between deframer,
// scrambler array and transport layer.
interface jesd204b_scrambler_array_if #(
  parameter int LANES = 4,
  parameter int DW    = 32
);

  logic                valid;
  logic [LANES*DW-1:0] data;

  modport master (
    output valid,
    output data
  );

  modport slave (
    input valid,
    input data
  );

endinterface

// File: rtl/jesd204b_scrambler_array_lane.sv
// One lane of the self-synchronous scrambler:
// state register, unrolled XOR chain, bypass mux.
module jesd204b_scr_lane
  import jesd204b_pkg::*;
#(
  parameter int                       DW       = 32,
  parameter int                       SCRAMBLE = 0,
  parameter logic [JESD_SCR_LEN-1:0]  SEED     = JESD_SCR_SEED_DEF
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          valid,
  input  logic [DW-1:0] data,
  input  logic          bypass,
  input  logic          seed_load,
  output logic [DW-1:0] dout
);

  logic [JESD_SCR_LEN-1:0]    state;
  logic [DW+JESD_SCR_LEN-1:0] ext;
  logic [DW-1:0]              proc;

  // ext low bits become the line stream: raw input
  // when descrambling, freshly scrambled bits otherwise.
  always_comb begin
    ext  = {state, data};
    proc = '0;
    for (int i = DW-1; i >= 0; i--) begin
      proc[i] = data[i]
              ^ ext[i+JESD_SCR_TAP_A]
              ^ ext[i+JESD_SCR_TAP_B];
      if (SCRAMBLE != 0) begin
        ext[i] = proc[i];
      end
    end
  end

  assign dout = bypass ? data : proc;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= SEED;
    end else if (seed_load) begin
      state <= SEED;
    end else if (valid) begin
      state <= ext[JESD_SCR_LEN-1:0];
    end
  end

endmodule

// File: rtl/jesd204b_scrambler_array.sv
// Multi-lane JESD204B scrambler/descrambler with
// shared handshake, bypass, seed reload and lock flag.
module jesd204b_scrambler_array
  import jesd204b_pkg::*;
#(
  parameter int                       LANES    = 4,
  parameter int                       DW       = 32,
  parameter int                       SCRAMBLE = 0,
  parameter logic [JESD_SCR_LEN-1:0]  SEED     = JESD_SCR_SEED_DEF
) (
  input  logic                        clk,
  input  logic                        reset_b,
  jesd204b_scrambler_array_if.slave   s,
  jesd204b_scrambler_array_if.master  m,
  input  logic                        bypass,
  input  logic                        seed_load,
  output logic                        m_locked
);

  logic [LANES*DW-1:0] lane_out;
  lock_state_t         lk_q;
  lock_state_t         lk_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    jesd204b_scr_lane #(
      .DW       (DW),
      .SCRAMBLE (SCRAMBLE),
      .SEED     (SEED)
    ) u_lane (
      .clk       (clk),
      .reset_b   (reset_b),
      .valid     (s.valid),
      .data      (s.data[l*DW +: DW]),
      .bypass    (bypass),
      .seed_load (seed_load),
      .dout      (lane_out[l*DW +: DW])
    );
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      m.valid <= 1'b0;
      m.data  <= '0;
    end else begin
      m.valid <= s.valid;
      if (s.valid) begin
        m.data <= lane_out;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      lk_q <= LK_UNLOCKED;
    end else begin
      lk_q <= lk_d;
    end
  end

  // A scrambler output never depends on history it
  // has not produced itself, so it locks on beat one.
  always_comb begin
    lk_d = lk_q;
    if (seed_load) begin
      lk_d = LK_UNLOCKED;
    end else if (s.valid) begin
      unique case (lk_q)
        LK_UNLOCKED:
          lk_d = (SCRAMBLE != 0) ? LK_LOCKED
                                 : LK_ONE_SEEN;
        LK_ONE_SEEN: lk_d = LK_LOCKED;
        LK_LOCKED:   lk_d = LK_LOCKED;
        default:     lk_d = LK_UNLOCKED;
      endcase
    end
  end

  assign m_locked = (lk_q == LK_LOCKED);

endmodule

// File: tb/tb_jesd204b_scrambler_array.sv
// Bench: scrambler -> descramblers chain plus a
// single-lane zero-seed descrambler, serial bit model.
module tb_jesd204b_scrambler_array;

  localparam logic [14:0] SD = 15'h7F80;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  logic byp_dsc, sl_scr, sl_dsc, one_sl, zero;
  logic scr_lk, dsc_lk, dsc0_lk, one_lk;

  jesd204b_scrambler_array_if #(.LANES(4), .DW(32)) src_if ();
  jesd204b_scrambler_array_if #(.LANES(4), .DW(32)) scr_if ();
  jesd204b_scrambler_array_if #(.LANES(4), .DW(32)) rec_if ();
  jesd204b_scrambler_array_if #(.LANES(4), .DW(32)) rec0_if ();
  jesd204b_scrambler_array_if #(.LANES(1), .DW(32)) one_in ();
  jesd204b_scrambler_array_if #(.LANES(1), .DW(32)) one_out ();

  jesd204b_scrambler_array #(
    .LANES(4), .DW(32), .SCRAMBLE(1), .SEED(SD)
  ) u_scr (
    .clk(clk), .reset_b(reset_b), .s(src_if), .m(scr_if),
    .bypass(zero), .seed_load(sl_scr), .m_locked(scr_lk)
  );

  jesd204b_scrambler_array #(
    .LANES(4), .DW(32), .SCRAMBLE(0), .SEED(SD)
  ) u_dsc (
    .clk(clk), .reset_b(reset_b), .s(scr_if), .m(rec_if),
    .bypass(byp_dsc), .seed_load(sl_dsc), .m_locked(dsc_lk)
  );

  jesd204b_scrambler_array #(
    .LANES(4), .DW(32), .SCRAMBLE(0), .SEED(15'h0)
  ) u_dsc0 (
    .clk(clk), .reset_b(reset_b), .s(scr_if), .m(rec0_if),
    .bypass(zero), .seed_load(sl_dsc), .m_locked(dsc0_lk)
  );

  jesd204b_scrambler_array #(
    .LANES(1), .DW(32), .SCRAMBLE(0), .SEED(15'h0)
  ) u_one (
    .clk(clk), .reset_b(reset_b), .s(one_in), .m(one_out),
    .bypass(zero), .seed_load(one_sl), .m_locked(one_lk)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: each lane is a serial line; h[k-1] is the
  // line bit k positions earlier on the wire.
  bit          m_scr  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [14:0] m_seed [4] = '{SD, SD, 15'h0, 15'h0};
  int          m_lanes[4] = '{4, 4, 4, 1};
  logic [14:0] mh[4][4];
  logic [127:0] md[4];
  bit          mv[4];
  int          mcnt[4];
  logic [127:0] srcq[$];
  bit          rt_chk;
  logic [127:0] rt_exp;
  int          s0_kind;
  logic [127:0] s0_exp;

  function automatic void lane_step(input bit scr,
                                    input logic [14:0] hi,
                                    input logic [31:0] d,
                                    output logic [31:0] o,
                                    output logic [14:0] ho);
    logic [14:0] h;
    logic        b;
    h = hi;
    o = '0;
    for (int i = 31; i >= 0; i--) begin
      o[i] = d[i] ^ h[13] ^ h[14];
      b    = scr ? o[i] : d[i];
      h    = {h[13:0], b};
    end
    ho = h;
  endfunction

  function automatic bit exp_lk(input int k);
    return mcnt[k] >= (m_scr[k] ? 1 : 2);
  endfunction

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 4; l++) mh[k][l] = m_seed[k];
      md[k] = '0;
      mv[k] = 1'b0;
      mcnt[k] = 0;
    end
    srcq.delete();
    rt_chk = 1'b0;
    s0_kind = 0;
  endtask

  task automatic m_step(input int k, input bit v,
                        input logic [127:0] d,
                        input bit byp, input bit sl);
    logic [31:0] o;
    logic [14:0] hn;
    if (v) begin
      for (int l = 0; l < m_lanes[k]; l++) begin
        lane_step(m_scr[k], mh[k][l], d[l*32 +: 32], o, hn);
        md[k][l*32 +: 32] = byp ? d[l*32 +: 32] : o;
        if (!sl) mh[k][l] = hn;
      end
    end
    if (sl) begin
      for (int l = 0; l < 4; l++) mh[k][l] = m_seed[k];
      mcnt[k] = 0;
    end else if (v) begin
      mcnt[k]++;
    end
    mv[k] = v;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_b);
      if (!reset_b) begin
        m_reset();
      end else begin
        logic [127:0] s;
        bit pend;
        pend = mv[0];
        s = '0;
        if (pend && srcq.size() > 0) s = srcq.pop_front();
        m_step(1, mv[0], md[0], byp_dsc, sl_dsc);
        m_step(2, mv[0], md[0], 1'b0, sl_dsc);
        rt_chk = pend;
        rt_exp = byp_dsc ? md[0] : s;
        s0_exp = s;
        s0_kind = (!pend || sl_dsc) ? 0 :
                  (mcnt[2] == 1) ? 1 : 2;
        m_step(0, src_if.valid, src_if.data, 1'b0, sl_scr);
        if (src_if.valid) srcq.push_back(src_if.data);
        m_step(3, one_in.valid, {96'b0, one_in.data}, 1'b0, one_sl);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("scr_beat", {scr_if.valid, scr_lk, scr_if.data},
          {mv[0], exp_lk(0), md[0]});
      chk("dsc_beat", {rec_if.valid, dsc_lk, rec_if.data},
          {mv[1], exp_lk(1), md[1]});
      chk("dsc0_beat", {rec0_if.valid, dsc0_lk, rec0_if.data},
          {mv[2], exp_lk(2), md[2]});
      chk("one_beat", {one_out.valid, one_lk, one_out.data},
          {mv[3], exp_lk(3), md[3][31:0]});
      if (rt_chk) chk("round_trip", rec_if.data, rt_exp);
      if (s0_kind == 1)
        chk("selfsync_beat1_differs", rec0_if.data != s0_exp, 1);
      if (s0_kind == 2)
        chk("selfsync_match", rec0_if.data, s0_exp);
    end
  end

  initial begin
    reset_b = 1'b0;
    byp_dsc = 1'b0; sl_scr = 1'b0; sl_dsc = 1'b0;
    one_sl = 1'b0; zero = 1'b0;
    src_if.valid = 1'b0; src_if.data = '0;
    one_in.valid = 1'b0; one_in.data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {rec_if.valid, dsc_lk, rec_if.data}, '0);
    chk("reset_one", {one_out.valid, one_lk, one_out.data}, '0);
    reset_b = 1'b1;

    one_in.valid = 1'b1;
    one_in.data = 32'h0000_0001;
    @(posedge clk); #1;
    chk("impulse_out0", {one_lk, one_out.data}, {1'b0, 32'h0000_0001});
    one_in.data = '0;
    @(posedge clk); #1;
    chk("impulse_out1", {one_lk, one_out.data}, {1'b1, 32'h0006_0000});
    @(posedge clk); #1;
    chk("impulse_out2", {one_lk, one_out.data}, {1'b1, 32'h0});
    one_in.valid = 1'b0;
    one_sl = 1'b1;
    @(posedge clk); #1;
    one_sl = 1'b0;
    chk("seed_load_unlock", one_lk, 0);
    one_in.valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); #1;
      chk("zero_beat", {one_lk, one_out.data},
          {(b > 0) ? 1'b1 : 1'b0, 32'h0});
    end
    one_in.valid = 1'b0;

    src_if.valid = 1'b1;
    src_if.data = rnd();
    @(posedge clk); #1;
    chk("scr_lock_first", {scr_if.valid, scr_lk}, 2'b11);
    src_if.data = rnd();
    @(posedge clk); #1;
    chk("dsc0_lock_beat1", {rec0_if.valid, dsc0_lk}, 2'b10);
    src_if.valid = 1'b0;
    @(posedge clk); #1;
    chk("dsc0_lock_beat2", {rec0_if.valid, dsc0_lk}, 2'b11);

    for (int n = 0; n < 1000; n++) begin
      src_if.valid = ($urandom_range(0, 3) != 0)
                  || (n >= 295 && n <= 305)
                  || (n >= 495 && n <= 506)
                  || (n >= 695 && n <= 700);
      src_if.data = rnd();
      sl_scr = (n == 300);
      sl_dsc = (n == 301);
      byp_dsc = (n >= 500 && n < 505);
      if (n == 700) begin
        #2;
        reset_b = 1'b0;
        #1;
        chk("async_reset_rec", {rec_if.valid, dsc_lk, rec_if.data}, '0);
        chk("async_reset_scr", {scr_if.valid, scr_lk, scr_if.data}, '0);
        reset_b = 1'b1;
      end
      @(posedge clk); #1;
      if (n == 300) chk("scr_seed_load_unlock", scr_lk, 0);
      if (n == 301) chk("dsc_seed_load_unlock", dsc_lk, 0);
    end

    src_if.valid = 1'b0;
    sl_scr = 1'b0; sl_dsc = 1'b0; byp_dsc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
